// File: rtl/csc_pkg.sv
// Shared definitions for the colour-space converter: mode encodings, pipeline
// latency, BT.601/BT.709 full-range coefficients (Q2.16) and output saturation.
package csc_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_601    = 2'd1,
        MODE_709    = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_e;

    localparam int unsigned LATENCY    = 5;
    localparam int unsigned COEF_W_DEF = 18;
    localparam int unsigned OUT_W_MAX  = 12;

    typedef logic signed [COEF_W_DEF-1:0] coef_t;

    // Rows Y/Cb/Cr, columns R/G/B
    localparam coef_t COEF_601 [3][3] = '{
        '{ 18'sd19595,  18'sd38470,  18'sd7471 },
        '{-18'sd11058, -18'sd21710,  18'sd32768},
        '{ 18'sd32768, -18'sd27439, -18'sd5329 }
    };

    localparam coef_t COEF_709 [3][3] = '{
        '{ 18'sd13933,  18'sd46871,  18'sd4732 },
        '{-18'sd7509,  -18'sd25259,  18'sd32768},
        '{ 18'sd32768, -18'sd29763, -18'sd3005 }
    };

    // Saturate an already-shifted signed result to [0, 2^data_w-1]
    function automatic logic [OUT_W_MAX-1:0] clamp_u(input logic signed [31:0] acc,
                                                     input int unsigned data_w);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< data_w) - 32'sd1;
        if (acc < 32'sd0)
            return '0;
        else if (acc > max_v)
            return OUT_W_MAX'(max_v);
        else
            return OUT_W_MAX'(acc);
    endfunction

endpackage

// File: rtl/csc_lane.sv
// One-pixel colour-space conversion lane: five registered stages, with the mode
// carried alongside the data so a mode change never splits a pixel.
module csc_lane
    import csc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned COEF_FRAC = 16,
    parameter logic [1:0]  MODE_RST  = MODE_601
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [3*DATA_W-1:0]   pixel_in,
    output logic [3*DATA_W-1:0]   pixel_out
);

    localparam int unsigned PIX_W = 3 * DATA_W;
    localparam int unsigned XW    = DATA_W + 1;
    localparam int unsigned PW    = XW + COEF_W;
    localparam int unsigned ACC_W = DATA_W + COEF_W + 3;

    localparam logic signed [ACC_W-1:0] OFF_C = ACC_W'(64'sd1 <<< (DATA_W - 1 + COEF_FRAC));
    localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(64'sd1 <<< (COEF_FRAC - 1));

    logic [PIX_W-1:0] pix1, pix2, pix3, pix4;
    logic [1:0]       mode1, mode2, mode3, mode4;

    logic signed [XW-1:0]     x    [3];
    logic signed [COEF_W-1:0] coef [3][3];
    logic signed [PW-1:0]     prod [3][3];
    logic signed [ACC_W-1:0]  part_a [3];
    logic signed [ACC_W-1:0]  part_b [3];
    logic signed [ACC_W-1:0]  acc    [3];
    logic signed [ACC_W-1:0]  shifted [3];
    logic [DATA_W-1:0]        res    [3];

    // Zero-extended components and the coefficient set for the S1 pixel's mode
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            x[c] = signed'({1'b0, pix1[(3-c)*DATA_W-1 -: DATA_W]});
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                coef[r][c] = (mode1 == MODE_709) ? COEF_W'(COEF_709[r][c])
                                                 : COEF_W'(COEF_601[r][c]);
            end
        end
    end

    // S5 arithmetic: drop the fraction, then saturate
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            shifted[r] = acc[r] >>> COEF_FRAC;
            res[r]     = DATA_W'(clamp_u(32'(shifted[r]), DATA_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix1  <= '0;
            pix2  <= '0;
            pix3  <= '0;
            pix4  <= '0;
            mode1 <= MODE_RST;
            mode2 <= MODE_RST;
            mode3 <= MODE_RST;
            mode4 <= MODE_RST;
            for (int r = 0; r < 3; r++) begin
                part_a[r] <= '0;
                part_b[r] <= '0;
                acc[r]    <= '0;
                for (int c = 0; c < 3; c++) begin
                    prod[r][c] <= '0;
                end
            end
            pixel_out <= '0;
        end else begin
            // S1
            pix1  <= pixel_in;
            mode1 <= mode;
            // S2
            pix2  <= pix1;
            mode2 <= mode1;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod[r][c] <= PW'(x[c]) * PW'(coef[r][c]);
                end
            end
            // S3
            pix3  <= pix2;
            mode3 <= mode2;
            for (int r = 0; r < 3; r++) begin
                part_a[r] <= ACC_W'(prod[r][0]) + ACC_W'(prod[r][1]);
                part_b[r] <= ACC_W'(prod[r][2]);
            end
            // S4: chroma rows are centred at mid-scale
            pix4  <= pix3;
            mode4 <= mode3;
            for (int r = 0; r < 3; r++) begin
                acc[r] <= part_a[r] + part_b[r] + ((r == 0) ? '0 : OFF_C) + RND_C;
            end
            // S5
            case (mode4)
                MODE_BYPASS: pixel_out <= pix4;
                MODE_GRAY:   pixel_out <= {res[0], res[0], res[0]};
                default:     pixel_out <= {res[0], res[1], res[2]};
            endcase
        end
    end

endmodule

// File: rtl/csc_pipeline.sv
// Multi-lane colour-space converter top: frame-boundary mode latch, sync delay
// line matched to the lane latency, and PPC conversion lanes.
module csc_pipeline
    import csc_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PPC       = 1,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned COEF_FRAC = 16,
    parameter logic [1:0]  MODE_RST  = MODE_601
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode_in,
    input  logic                      de_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [3*DATA_W*PPC-1:0]   pixel_in,
    output logic                      de_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [3*DATA_W*PPC-1:0]   pixel_out,
    output logic [1:0]                mode_active
);

    localparam int unsigned PIX_W = 3 * DATA_W;

    logic               vsync_d;
    logic [1:0]         mode_cur;
    logic [LATENCY-1:0] de_d, hs_d, vs_d;
    logic               vsync_rise_c;

    assign vsync_rise_c = vsync_in & ~vsync_d;

    // Mode changes only on a vsync rising edge; the edge-cycle pixel keeps the old mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d  <= 1'b0;
            mode_cur <= MODE_RST;
            de_d     <= '0;
            hs_d     <= '0;
            vs_d     <= '0;
        end else begin
            vsync_d <= vsync_in;
            if (vsync_rise_c) begin
                mode_cur <= mode_in;
            end
            de_d <= {de_d[LATENCY-2:0], de_in};
            hs_d <= {hs_d[LATENCY-2:0], hsync_in};
            vs_d <= {vs_d[LATENCY-2:0], vsync_in};
        end
    end

    assign de_out      = de_d[LATENCY-1];
    assign hsync_out   = hs_d[LATENCY-1];
    assign vsync_out   = vs_d[LATENCY-1];
    assign mode_active = mode_cur;

    for (genvar k = 0; k < PPC; k++) begin : g_lane
        csc_lane #(
            .DATA_W    (DATA_W),
            .COEF_W    (COEF_W),
            .COEF_FRAC (COEF_FRAC),
            .MODE_RST  (MODE_RST)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .mode      (mode_cur),
            .pixel_in  (pixel_in[k*PIX_W +: PIX_W]),
            .pixel_out (pixel_out[k*PIX_W +: PIX_W])
        );
    end

endmodule
